// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 4 KiB instruction memory: decodes
// base/length header, writes data bytes one per cycle, checks XOR checksum.
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, ADDR1, LEN0, LEN1, DATA, CSUM, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [5:0]        a_lo;     // A0 bits [7:2]; bits [1:0] are forced to zero
  logic [7:0]        len_lo;
  logic [7:0]        csum;
  logic [CNT_W+1:0]  remain;   // remaining data bytes (4*N)
  logic              accept;
  logic [CNT_W-1:0]  len_full;

  assign accept   = in_valid & in_ready;
  assign len_full = CNT_W'({in_data, len_lo});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ptr       <= '0;
      a_lo      <= '0;
      len_lo    <= '0;
      csum      <= '0;
      remain    <= '0;
    end else begin
      mem_we   <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          a_lo  <= in_data[7:2];
          csum  <= '0;
          err   <= 1'b0;
          busy  <= 1'b1;
          state <= ADDR1;
        end
        ADDR1: if (accept) begin
          ptr   <= ADDR_W'({in_data, a_lo, 2'b00});
          state <= LEN0;
        end
        LEN0: if (accept) begin
          len_lo <= in_data;
          state  <= LEN1;
        end
        LEN1: if (accept) begin
          remain <= {len_full, 2'b00};
          state  <= (len_full == '0) ? CSUM : DATA;
        end
        DATA: if (accept) begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= in_data;
          ptr       <= ptr + 1'b1;
          csum      <= csum ^ in_data;
          remain    <= remain - 1'b1;
          if (remain == (CNT_W+2)'(1)) state <= CSUM;
        end
        CSUM: if (accept) begin
          err      <= (in_data != csum);
          done     <= 1'b1;
          in_ready <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench: driver pushes expected writes/done events computed from
// the frame contents; a negedge monitor pops and compares them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, busy, done, err;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;

  imem_loader #(.ADDR_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [11:0] addr; logic [7:0] d; } wr_t;
  typedef struct { int cyc; logic e; } dn_t;

  wr_t  exp_wr[$];
  dn_t  exp_dn[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  logic [7:0] img [4096];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count++;
      img[mem_addr] = mem_wdata;
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %h data %h (cycle %0d)", mem_addr, mem_wdata, cyc);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("write_addr", {20'd0, mem_addr}, {20'd0, w.addr});
        chk("write_data", {24'd0, mem_wdata}, {24'd0, w.d});
        chk("write_cycle", cyc, w.cyc);
      end
    end
    if (done === 1'b1) begin
      if (exp_dn.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        dn_t d;
        d = exp_dn.pop_front();
        chk("done_cycle", cyc, d.cyc);
        chk("done_err", {31'd0, err}, {31'd0, d.e});
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  // kind: 0 header, 1 data (expects write at eaddr), 2 checksum (expects done with eerr)
  task automatic send_byte(input logic [7:0] b, input int kind, input logic [11:0] eaddr,
                           input logic eerr, input bit gap);
    int   c;
    logic rdy;
    int   n;
    if (gap) begin
      @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
    end
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b1; in_data = b; c = cyc; rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end else if (kind == 1) begin
      exp_wr.push_back('{c + 1, eaddr, b});
    end else if (kind == 2) begin
      exp_dn.push_back('{c + 1, eerr});
    end
  endtask

  // Reference model: writes land at aligned base + i (mod 4096); err iff C != XOR(data).
  task automatic send_frame(input logic [15:0] base, input logic [7:0] dat[$],
                            input logic [7:0] c, input int stall);
    logic [11:0] b0;
    logic [7:0]  x;
    int          n;
    n  = dat.size() / 4;
    b0 = base[11:0] & 12'hFFC;
    x  = 8'h00;
    foreach (dat[i]) x ^= dat[i];
    send_byte(base[7:0], 0, 12'h0, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    chk("busy_after_a0", {31'd0, busy}, 32'd1);
    chk("err_cleared_a0", {31'd0, err}, 32'd0);
    send_byte(base[15:8], 0, 12'h0, 1'b0, 1'b0);
    send_byte(n[7:0], 0, 12'h0, 1'b0, 1'b0);
    send_byte(n[15:8], 0, 12'h0, 1'b0, 1'b0);
    foreach (dat[i]) begin
      bit g;
      g = (stall == 1) ? (i > 0) : (stall == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
      send_byte(dat[i], 1, 12'((int'(b0) + i) % 4096), 1'b0, g);
    end
    send_byte(c, 2, 12'h0, (c != x), 1'b0);
    @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic settle(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q[$];
    int wc0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_outs", {mem_we, busy, done, err, mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;

    // Basic load
    q = '{8'h13, 8'h00, 8'h50, 8'h00};
    send_frame(16'h0100, q, 8'h43, 0);
    settle(3);
    chk("imem_word_0x100", {img[12'h103], img[12'h102], img[12'h101], img[12'h100]}, 32'h00500013);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Alignment and wrap
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(16'h0FFE, q, 8'h08, 0);
    settle(3);

    // XOR of AA BB CC DD is 00, so C=00 is a good checksum; then a real mismatch
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(16'h0200, q, 8'h00, 0);
    send_frame(16'h0300, q, 8'h5A, 0);
    settle(2);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Zero length (its A0 also clears err)
    q = {};
    send_frame(16'h0400, q, 8'h00, 0);
    settle(2);

    // Stalls every other cycle during data
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(16'h0500, q, 8'h88, 1);
    settle(3);

    // Reset mid-frame after 3rd data byte of an N=2 frame
    wc0 = wr_count;
    send_byte(8'h00, 0, 12'h0, 1'b0, 1'b0);
    send_byte(8'h06, 0, 12'h0, 1'b0, 1'b0);
    send_byte(8'h02, 0, 12'h0, 1'b0, 1'b0);
    send_byte(8'h00, 0, 12'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1, 12'h600 + 12'(i), 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    settle(2);
    chk("rst_mid_writes", wr_count - wc0, 3);
    q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_frame(16'h0600, q, 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0, 0);
    settle(3);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      logic [7:0] x;
      logic [7:0] c;
      int n;
      n = $urandom_range(0, 4);
      q = {};
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        q.push_back(8'($urandom));
        x ^= q[i];
      end
      c = ($urandom_range(0, 1) == 1) ? x : (x ^ 8'($urandom_range(1, 255)));
      send_frame(16'($urandom), q, c, 2);
      settle($urandom_range(0, 3));
    end

    settle(5);
    chk("writes_drained", exp_wr.size(), 0);
    chk("dones_drained", exp_dn.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
